// File: rtl/studio2_pkg.sv
// rtl/studio2_pkg.sv - shared types, scancode table and decode helper for the Studio II keypad
package studio2_pkg;

    localparam int KEY_COUNT = 10;

    // Keypad A: main-row digit keys (set 2 scancodes)
    localparam logic [7:0] SC_A0 = 8'h45;
    localparam logic [7:0] SC_A1 = 8'h16;
    localparam logic [7:0] SC_A2 = 8'h1E;
    localparam logic [7:0] SC_A3 = 8'h26;
    localparam logic [7:0] SC_A4 = 8'h25;
    localparam logic [7:0] SC_A5 = 8'h2E;
    localparam logic [7:0] SC_A6 = 8'h36;
    localparam logic [7:0] SC_A7 = 8'h3D;
    localparam logic [7:0] SC_A8 = 8'h3E;
    localparam logic [7:0] SC_A9 = 8'h46;

    // Keypad B: numeric keypad, non-extended codes
    localparam logic [7:0] SC_B0 = 8'h70;
    localparam logic [7:0] SC_B1 = 8'h69;
    localparam logic [7:0] SC_B2 = 8'h72;
    localparam logic [7:0] SC_B3 = 8'h7A;
    localparam logic [7:0] SC_B4 = 8'h6B;
    localparam logic [7:0] SC_B5 = 8'h73;
    localparam logic [7:0] SC_B6 = 8'h74;
    localparam logic [7:0] SC_B7 = 8'h6C;
    localparam logic [7:0] SC_B8 = 8'h75;
    localparam logic [7:0] SC_B9 = 8'h7D;

    typedef enum logic {PAD_IDLE, PAD_HOLD} pad_state_t;

    typedef struct packed {
        logic       valid;
        logic       pad;    // 0 = keypad A, 1 = keypad B
        logic [3:0] digit;
    } key_map_t;

    function automatic key_map_t scan_to_key(input logic [7:0] scancode);
        key_map_t m;
        m = '0;
        case (scancode)
            SC_A0: m = {1'b1, 1'b0, 4'd0};
            SC_A1: m = {1'b1, 1'b0, 4'd1};
            SC_A2: m = {1'b1, 1'b0, 4'd2};
            SC_A3: m = {1'b1, 1'b0, 4'd3};
            SC_A4: m = {1'b1, 1'b0, 4'd4};
            SC_A5: m = {1'b1, 1'b0, 4'd5};
            SC_A6: m = {1'b1, 1'b0, 4'd6};
            SC_A7: m = {1'b1, 1'b0, 4'd7};
            SC_A8: m = {1'b1, 1'b0, 4'd8};
            SC_A9: m = {1'b1, 1'b0, 4'd9};
            SC_B0: m = {1'b1, 1'b1, 4'd0};
            SC_B1: m = {1'b1, 1'b1, 4'd1};
            SC_B2: m = {1'b1, 1'b1, 4'd2};
            SC_B3: m = {1'b1, 1'b1, 4'd3};
            SC_B4: m = {1'b1, 1'b1, 4'd4};
            SC_B5: m = {1'b1, 1'b1, 4'd5};
            SC_B6: m = {1'b1, 1'b1, 4'd6};
            SC_B7: m = {1'b1, 1'b1, 4'd7};
            SC_B8: m = {1'b1, 1'b1, 4'd8};
            SC_B9: m = {1'b1, 1'b1, 4'd9};
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/studio2_keypad_pad.sv
// rtl/studio2_keypad_pad.sv - one 10-key pad: key state with minimum-hold stretch
// Ports: clk, reset_n (sync, active-low), press_stb/release_stb + digit (one decoded
// event per cycle), keys (registered key-down state, bit n = digit n).
module studio2_keypad_pad
    import studio2_pkg::*;
#(
    parameter int HOLD_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 press_stb,
    input  logic                 release_stb,
    input  logic [3:0]           digit,
    output logic [KEY_COUNT-1:0] keys
);

    localparam int TW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMR_LOAD = (HOLD_CYCLES > 0) ? TW'(HOLD_CYCLES - 1) : '0;

    pad_state_t           state_q, state_d;
    logic [KEY_COUNT-1:0] keys_q, keys_d;
    logic [KEY_COUNT-1:0] pend_q, pend_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [KEY_COUNT-1:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            mask[i] = (digit == 4'(i));
        end

        state_d = state_q;
        keys_d  = keys_q;
        pend_d  = pend_q;
        tmr_d   = tmr_q;

        // Expiry first, so a same-cycle event sees the post-expiry state.
        if (state_q == PAD_HOLD) begin
            if (tmr_q == '0) begin
                keys_d  = keys_q & ~pend_q;
                pend_d  = '0;
                state_d = PAD_IDLE;
            end else begin
                tmr_d = tmr_q - TW'(1);
            end
        end

        if (press_stb) begin
            keys_d = keys_d | mask;
            pend_d = pend_d & ~mask;
            if (HOLD_CYCLES != 0) begin
                tmr_d   = TMR_LOAD;
                state_d = PAD_HOLD;
            end
        end else if (release_stb) begin
            // While stretching, a release is only remembered; it lands at expiry.
            if (state_d == PAD_HOLD) begin
                pend_d = pend_d | mask;
            end else begin
                keys_d = keys_d & ~mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= PAD_IDLE;
            keys_q  <= '0;
            pend_q  <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
            pend_q  <= pend_d;
            tmr_q   <= tmr_d;
        end
    end

    assign keys = keys_q;

endmodule

// File: rtl/studio2_keypad.sv
// rtl/studio2_keypad.sv - PS/2 events to two RCA Studio II keypads and EF3/EF4 sense lines
// Ports: clk_sys, reset_n (sync, active-low), ps2_key (hps_io event), key_sel_we/key_sel_din
// (CPU OUT 2 key select), ef3/ef4 (selected key down on pad A/B), key_any, keys_a, keys_b.
module studio2_keypad
    import studio2_pkg::*;
#(
    parameter int HOLD_CYCLES = 500000
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic [10:0]          ps2_key,
    input  logic                 key_sel_we,
    input  logic [3:0]           key_sel_din,
    output logic                 ef3,
    output logic                 ef4,
    output logic                 key_any,
    output logic [KEY_COUNT-1:0] keys_a,
    output logic [KEY_COUNT-1:0] keys_b
);

    logic       tog_q, tog_d;
    logic [3:0] sel_q, sel_d;
    logic       ef3_q, ef3_d;
    logic       ef4_q, ef4_d;
    logic       key_any_q, key_any_d;

    key_map_t   map;
    logic       evt;
    logic       press_a, release_a, press_b, release_b;
    logic [15:0] keys_a_ext, keys_b_ext;

    always_comb begin
        map       = scan_to_key(ps2_key[7:0]);
        evt       = (ps2_key[10] != tog_q) && map.valid && !ps2_key[8];
        press_a   = evt && !map.pad &&  ps2_key[9];
        release_a = evt && !map.pad && !ps2_key[9];
        press_b   = evt &&  map.pad &&  ps2_key[9];
        release_b = evt &&  map.pad && !ps2_key[9];

        // tog_q simply follows the strobe; reloading it in reset suppresses a stale event.
        tog_d = ps2_key[10];
        sel_d = key_sel_we ? key_sel_din : sel_q;

        // Zero-extend so selector codes 10..15 read as 0 without an out-of-range index.
        keys_a_ext = {6'b0, keys_a};
        keys_b_ext = {6'b0, keys_b};
        ef3_d      = keys_a_ext[sel_q];
        ef4_d      = keys_b_ext[sel_q];
        key_any_d  = |{keys_a, keys_b};
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            tog_q     <= ps2_key[10];
            sel_q     <= '0;
            ef3_q     <= 1'b0;
            ef4_q     <= 1'b0;
            key_any_q <= 1'b0;
        end else begin
            tog_q     <= tog_d;
            sel_q     <= sel_d;
            ef3_q     <= ef3_d;
            ef4_q     <= ef4_d;
            key_any_q <= key_any_d;
        end
    end

    studio2_keypad_pad #(.HOLD_CYCLES(HOLD_CYCLES)) u_pad_a (
        .clk         (clk_sys),
        .reset_n     (reset_n),
        .press_stb   (press_a),
        .release_stb (release_a),
        .digit       (map.digit),
        .keys        (keys_a)
    );

    studio2_keypad_pad #(.HOLD_CYCLES(HOLD_CYCLES)) u_pad_b (
        .clk         (clk_sys),
        .reset_n     (reset_n),
        .press_stb   (press_b),
        .release_stb (release_b),
        .digit       (map.digit),
        .keys        (keys_b)
    );

    assign ef3     = ef3_q;
    assign ef4     = ef4_q;
    assign key_any = key_any_q;

endmodule

// File: tb/tb_studio2_keypad.sv
// tb/tb_studio2_keypad.sv - directed self-checking bench for studio2_keypad
module tb_studio2_keypad;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        key_sel_we;
    logic [3:0]  key_sel_din;
    logic        ef3, ef4, key_any;
    logic [9:0]  keys_a, keys_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] codes_a [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] codes_b [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    studio2_keypad #(.HOLD_CYCLES(8)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_key     (ps2_key),
        .key_sel_we  (key_sel_we),
        .key_sel_din (key_sel_din),
        .ef3         (ef3),
        .ef4         (ef4),
        .key_any     (key_any),
        .keys_a      (keys_a),
        .keys_b      (keys_b)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // New event; the DUT takes it at the next edge, keys_* visible right after.
    task automatic send(input logic [7:0] code, input logic ext, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, ext, code};
        tick();
    endtask

    task automatic select(input logic [3:0] s);
        key_sel_we  = 1'b1;
        key_sel_din = s;
        tick();
        key_sel_we  = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n     = 1'b0;
        ps2_key     = {1'b1, 1'b1, 1'b0, 8'h16};
        key_sel_we  = 1'b0;
        key_sel_din = 4'd0;
        tick(3);
        reset_n = 1'b1;
        tick(3);
        check("rst_keys_a", 16'(keys_a), 16'h000);
        check("rst_keys_b", 16'(keys_b), 16'h000);
        check("rst_ef3", 16'(ef3), 16'h0);
        check("rst_ef4", 16'(ef4), 16'h0);
        check("rst_any", 16'(key_any), 16'h0);

        // Pad A basic press of digit 1
        send(8'h16, 1'b0, 1'b1);
        check("a1_keys_a", 16'(keys_a), 16'h002);
        key_sel_we  = 1'b1;
        key_sel_din = 4'd1;
        tick();
        key_sel_we  = 1'b0;
        check("a1_ef3_early", 16'(ef3), 16'h0);
        tick();
        check("a1_ef3", 16'(ef3), 16'h1);
        check("a1_ef4", 16'(ef4), 16'h0);
        check("a1_any", 16'(key_any), 16'h1);

        // Release after the stretch has expired: immediate clear
        tick(10);
        send(8'h16, 1'b0, 1'b0);
        check("a1_rel_keys_a", 16'(keys_a), 16'h000);
        tick();
        check("a1_rel_ef3", 16'(ef3), 16'h0);

        // Stretch on B3: press at t=0, release at t=2, drop at t=8
        send(8'h7A, 1'b0, 1'b1);
        check("b3_press", 16'(keys_b), 16'h008);
        tick();
        send(8'h7A, 1'b0, 1'b0);
        tick(5);
        check("b3_hold_t7", 16'(keys_b), 16'h008);
        tick();
        check("b3_drop_t8", 16'(keys_b), 16'h000);

        // Extended 6B ignored, plain 6B sets B4
        send(8'h6B, 1'b1, 1'b1);
        check("b4_ext_ignored", 16'(keys_b), 16'h000);
        send(8'h6B, 1'b0, 1'b1);
        check("b4_press", 16'(keys_b), 16'h010);

        // Release in the tmr==0 cycle (edge t=8) clears at that edge
        tick(7);
        send(8'h6B, 1'b0, 1'b0);
        check("coll_release", 16'(keys_b), 16'h000);

        // Press in the tmr==0 cycle re-enters HOLD with a full count
        send(8'h6B, 1'b0, 1'b1);
        tick(7);
        send(8'h74, 1'b0, 1'b1);
        check("coll_press", 16'(keys_b), 16'h050);
        send(8'h74, 1'b0, 1'b0);
        tick(6);
        check("coll_hold_t7", 16'(keys_b), 16'h050);
        tick();
        check("coll_drop_t8", 16'(keys_b), 16'h010);

        // All 20 keys down
        for (int i = 0; i < 10; i++) begin
            send(codes_a[i], 1'b0, 1'b1);
            send(codes_b[i], 1'b0, 1'b1);
        end
        check("all_keys_a", 16'(keys_a), 16'h3FF);
        check("all_keys_b", 16'(keys_b), 16'h3FF);
        select(4'd5);
        check("sel5_ef3", 16'(ef3), 16'h1);
        check("sel5_ef4", 16'(ef4), 16'h1);
        select(4'd12);
        check("sel12_ef3", 16'(ef3), 16'h0);
        check("sel12_ef4", 16'(ef4), 16'h0);
        check("sel12_any", 16'(key_any), 16'h1);

        // Reset mid-HOLD, then a late release must have no effect
        send(8'h16, 1'b0, 1'b1);
        reset_n = 1'b0;
        tick();
        check("midrst_keys_a", 16'(keys_a), 16'h000);
        check("midrst_keys_b", 16'(keys_b), 16'h000);
        check("midrst_any", 16'(key_any), 16'h0);
        reset_n = 1'b1;
        send(8'h16, 1'b0, 1'b0);
        check("post_rst_rel", 16'(keys_a), 16'h000);
        tick();
        check("post_rst_any", 16'(key_any), 16'h0);
        check("post_rst_ef3", 16'(ef3), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/studio2_keypad.md
# studio2_keypad

Converts MiSTer PS/2 key events into the two 10-key RCA Studio II keypads and presents the CDP1802 EF3/EF4 key-sense lines to the `rcastudioii` core. It sits between `hps_io` (`ps2_key`) and the core.

- The CPU selects a key number with an OUT 2 write.
- EF3 reports whether that key is down on keypad A; EF4 does the same for keypad B.
- A per-pad minimum-hold stretch guarantees that short host taps are visible to the game's polling loop.

## Interface
- `HOLD_CYCLES`, default 500000: minimum `clk_sys` cycles a key reads as pressed after its last press event on that pad. A value of 0 disables stretching.
- `clk_sys`  in  1  system clock; every register is on its rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `ps2_key`  in  11  hps_io key event: [7:0] scancode, [8] extended, [9] pressed, [10] toggle strobe.
- `key_sel_we`  in  1  one-cycle strobe on CPU OUT 2.
- `key_sel_din`  in  4  data bus [3:0] qualified by `key_sel_we`.
- `ef3`  out  1  keypad A selected key pressed (active high).
- `ef4`  out  1  keypad B selected key pressed (active high).
- `key_any`  out  1  any of the 20 keys pressed.
- `keys_a`  out  10  keypad A state, bit n = digit n.
- `keys_b`  out  10  keypad B state, bit n = digit n.

## Operation
- **Event detect:** `tog_q` tracks `ps2_key[10]`. An event is any cycle where `ps2_key[10] != tog_q`. At reset, `tog_q` loads the current `ps2_key[10]`, so no spurious event fires.
- **Keypad A map** (main-row digits), with `ps2_key[8]`=0:
  - 0=45, 1=16, 2=1E, 3=26, 4=25
  - 5=2E, 6=36, 7=3D, 8=3E, 9=46
- **Keypad B map** (numeric keypad), with `ps2_key[8]`=0:
  - 0=70, 1=69, 2=72, 3=7A, 4=6B
  - 5=73, 6=74, 7=6C, 8=75, 9=7D
- Events that are extended or unmapped are ignored. Each event affects at most one pad.
- **Per-pad state:** `keys[9:0]`, `pend[9:0]`, down-counter `tmr`, and an FSM with states IDLE and HOLD.
- **Press of key n:**
  - `keys[n]`←1, `pend[n]`←0.
  - `tmr`←HOLD_CYCLES−1, state←HOLD.
  - With HOLD_CYCLES=0, state stays IDLE.
- **Release of key n:**
  - In HOLD: `pend[n]`←1 and `keys` is unchanged.
  - In IDLE: `keys[n]`←0.
- **HOLD behaviour:**
  - `tmr` decrements each cycle.
  - When `tmr`==0: `keys`←`keys & ~pend`, `pend`←0, state←IDLE.
- **Simultaneous expiry and event:** expiry is applied first, then the event is evaluated against the post-expiry state.
  - A release in that cycle clears its bit immediately.
  - A press in that cycle re-enters HOLD with a full `tmr`.
- **Repeated presses** (typematic) of a held key only restart `tmr`.
- **Selector:** `sel[3:0]` loads `key_sel_din` on `key_sel_we`.
  - For `sel` ≤ 9: `ef3`=`keys_a[sel]` and `ef4`=`keys_b[sel]`.
  - For `sel` 10–15: both are 0.
- **Reset values:**
  - All outputs 0.
  - `keys`, `pend`, `sel` = 0; `tmr` = 0; both FSMs IDLE.
- **Reset mid-HOLD:** clears all state in the same cycle. A release arriving after reset is processed as an IDLE release and has no effect.

## Timing
- `keys_a`/`keys_b` are registered and update 1 cycle after the event cycle.
- `ef3`, `ef4` and `key_any` are registered from `keys`/`sel`:
  - 2 cycles after a ps2 event;
  - 2 cycles after `key_sel_we`.
- **Stretch:** after a press at cycle P with no later press on that pad, a release that is already pending drops `keys` at cycle P+1+HOLD_CYCLES.
- **Throughput:** one ps2 event per cycle is accepted without loss. There is no backpressure.
- **Counter width:** `tmr` width is `$clog2(HOLD_CYCLES+1)`, minimum 1. The counter must not wrap below 0.

## Structure
- **Package `studio2_pkg`:**
  - `KEY_COUNT`=10;
  - the 20 scancode localparams;
  - `typedef enum logic {PAD_IDLE, PAD_HOLD} pad_state_t`;
  - function `scan_to_key(scancode) → {valid, pad, digit[3:0]}`.
- **Sub-module `studio2_keypad_pad`:** instantiated twice. It holds `keys`, `pend`, `tmr` and the FSM, and takes inputs `press_stb`, `release_stb` and `digit`.
- **Top level:** toggle detect, decode, selector register, and the EF/`key_any` output registers.

## Test plan
- **Reset:** hold `reset_n`=0 with `ps2_key[10]`=1, then release. All outputs must be 0 and no event may fire.
- **Pad A basic press:** toggle with code 16, pressed=1, then `key_sel_we` with 1. `keys_a`=10'h002 and `ef3`=1 two cycles after the write; `ef4`=0.
- **Stretch (HOLD_CYCLES=8):**
  - Press 7A (B3), release 2 cycles later. `keys_b[3]` stays 1 until P+9, then goes to 0.
  - Release with the pad in IDLE clears the bit the next cycle.
- **Extended code:** 6B with `ps2_key[8]`=1 produces no change. Then 6B with `ps2_key[8]`=0 sets `keys_b[4]`.
- **Expiry collision:** release arriving exactly in the `tmr`==0 cycle clears its bit at the next edge. A press in the same cycle yields HOLD with `tmr`=HOLD_CYCLES−1.
- **Selector out of range:** `sel`=12 with all keys down gives `ef3`=`ef4`=0 and `key_any`=1. Asserting `reset_n`=0 mid-HOLD clears everything in 1 cycle.
